timer_counter: RTL and testbench

- 8-bit up/down counter stage directly downstream of clock_select.
- Consumes the selected count clock `clk_in` as a level signal sampled in the `pclk` domain, and advances once per rising edge of `clk_in`.
- Provides parallel load from the data register, one-cycle overflow/underflow pulses and sticky status flags for the register/interrupt logic.

---
 rtl/timer_pkg.sv | 12 +
 rtl/edge_detect_rise.sv | 13 +
 rtl/timer_counter.sv | 66 ++++++
 tb/tb_timer_counter.sv | 103 ++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, clock-select encodings and count direction constants.
package timer_pkg;
  localparam int unsigned TMR_WIDTH = 8;
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/edge_detect_rise.sv
// edge_detect_rise: one-cycle tick on each sampled low-to-high transition of sig_in.
module edge_detect_rise (
  input  logic clk,
  input  logic sig_in,
  output logic tick
);
  logic dly_d, dly_q;
  // The delay register tracks the input even during reset, so a level held high
  // across reset release never looks like a fresh edge.
  always_comb dly_d = sig_in;
  always_ff @(posedge clk) dly_q <= dly_d;
  assign tick = sig_in & ~dly_q;
endmodule

// File: rtl/timer_counter.sv
// timer_counter: loadable up/down counter advanced by rising edges of clk_in, with wrap pulses and sticky flags.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned             WIDTH   = TMR_WIDTH,
  parameter logic [WIDTH-1:0]        MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             clk_in,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] tdr,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  output logic [WIDTH-1:0] tcnt,
  output logic             ovf_pulse,
  output logic             udf_pulse,
  output logic             ovf_flag,
  output logic             udf_flag
);
  logic             tick, count, wrap_up, wrap_dn;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             ovf_p_d, ovf_p_q, udf_p_d, udf_p_q;
  logic             ovf_f_d, ovf_f_q, udf_f_d, udf_f_q;
  edge_detect_rise u_edge (
    .clk    (pclk),
    .sig_in (clk_in),
    .tick   (tick)
  );
  // Load outranks counting; a tick coinciding with load is dropped.
  always_comb begin
    count   = ~load & en & tick;
    wrap_up = count & (up_down == DIR_UP) & (cnt_q == MAX_VAL);
    wrap_dn = count & (up_down == DIR_DOWN) & (cnt_q == '0);
    cnt_d   = load ? tdr :
              ~count ? cnt_q :
              (up_down == DIR_UP) ? (wrap_up ? '0 : cnt_q + WIDTH'(1)) :
              (wrap_dn ? MAX_VAL : cnt_q - WIDTH'(1));
    ovf_p_d = wrap_up;
    udf_p_d = wrap_dn;
    ovf_f_d = wrap_up | (ovf_f_q & ~clr_ovf);
    udf_f_d = wrap_dn | (udf_f_q & ~clr_udf);
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q   <= '0;
      ovf_p_q <= 1'b0;
      udf_p_q <= 1'b0;
      ovf_f_q <= 1'b0;
      udf_f_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_p_q <= ovf_p_d;
      udf_p_q <= udf_p_d;
      ovf_f_q <= ovf_f_d;
      udf_f_q <= udf_f_d;
    end
  end
  assign tcnt      = cnt_q;
  assign ovf_pulse = ovf_p_q;
  assign udf_pulse = udf_p_q;
  assign ovf_flag  = ovf_f_q;
  assign udf_flag  = udf_f_q;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed vector table plus hand sequences for reset, wrap and flag corners.
module tb_timer_counter;
  logic       pclk = 1'b0, preset, clk_in, en, up_down, load, clr_ovf, clr_udf;
  logic [7:0] tdr, tcnt;
  logic       ovf_pulse, udf_pulse, ovf_flag, udf_flag;
  int         checks = 0, errors = 0;
  typedef struct {
    logic       ld;
    logic [7:0] tdr;
    logic       en, ud, ci, co, cu;
    logic [7:0] et;
    logic       eop, eup, eof, euf;
  } vec_t;
  vec_t vq[$];
  timer_counter dut (
    .pclk(pclk), .preset(preset), .clk_in(clk_in), .en(en), .up_down(up_down),
    .load(load), .tdr(tdr), .clr_ovf(clr_ovf), .clr_udf(clr_udf), .tcnt(tcnt),
    .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse), .ovf_flag(ovf_flag), .udf_flag(udf_flag)
  );
  always #5 pclk = ~pclk;
  task automatic drive(input logic pr, ld, input logic [7:0] d, input logic e, ud, ci, co, cu);
    preset = pr; load = ld; tdr = d; en = e; up_down = ud; clk_in = ci; clr_ovf = co; clr_udf = cu;
    @(posedge pclk);
    @(negedge pclk);
  endtask
  task automatic check(input string name, input logic [7:0] et, input logic eop, eup, eof, euf);
    checks++;
    if ({tcnt, ovf_pulse, udf_pulse, ovf_flag, udf_flag} !== {et, eop, eup, eof, euf}) begin
      errors++;
      $display("FAIL %s: got tcnt=%h op=%b up=%b of=%b uf=%b, want tcnt=%h op=%b up=%b of=%b uf=%b",
               name, tcnt, ovf_pulse, udf_pulse, ovf_flag, udf_flag, et, eop, eup, eof, euf);
    end
  endtask
  initial begin
    // up wrap from FD
    vq.push_back('{1, 8'hFD, 1, 1, 0, 0, 0, 8'hFD, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'hFE, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 0, 0, 0, 8'hFE, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'hFF, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 0, 0, 0, 8'hFF, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'h00, 1, 0, 1, 0});
    vq.push_back('{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'h01, 0, 0, 1, 0});
    vq.push_back('{0, 8'h00, 1, 1, 0, 1, 0, 8'h01, 0, 0, 0, 0});
    // down wrap from 02, clear udf with en low
    vq.push_back('{1, 8'h02, 1, 0, 0, 0, 0, 8'h02, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 8'h01, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 8'h01, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 8'hFF, 0, 1, 0, 1});
    vq.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 1});
    vq.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 8'hFE, 0, 0, 0, 1});
    vq.push_back('{0, 8'h00, 0, 0, 0, 0, 1, 8'hFE, 0, 0, 0, 0});
    // load beats a coincident tick, which is not replayed later
    vq.push_back('{1, 8'h10, 1, 1, 0, 0, 0, 8'h10, 0, 0, 0, 0});
    vq.push_back('{1, 8'h80, 1, 1, 1, 0, 0, 8'h80, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'h80, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 0, 0, 0, 8'h80, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'h81, 0, 0, 0, 0});
    // enable gating at 33
    vq.push_back('{1, 8'h33, 1, 1, 0, 0, 0, 8'h33, 0, 0, 0, 0});
    for (int i = 0; i < 10; i++)
      vq.push_back('{0, 8'h00, 0, 1, logic'(i % 2 == 0), 0, 0, 8'h33, 0, 0, 0, 0});
    vq.push_back('{0, 8'h00, 1, 1, 1, 0, 0, 8'h34, 0, 0, 0, 0});
    // reset with clk_in high, released high: no count until a fresh rise
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h00, 1, 1, 1, 0, 0);
      check("reset", 8'h00, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 1, 1, 1, 0, 0);
      check("release_high", 8'h00, 0, 0, 0, 0);
    end
    drive(0, 0, 8'h00, 1, 1, 0, 0, 0);
    check("release_low", 8'h00, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 1, 0, 0);
    check("first_rise", 8'h01, 0, 0, 0, 0);
    foreach (vq[i]) begin
      drive(0, vq[i].ld, vq[i].tdr, vq[i].en, vq[i].ud, vq[i].ci, vq[i].co, vq[i].cu);
      check($sformatf("vec%0d", i), vq[i].et, vq[i].eop, vq[i].eup, vq[i].eof, vq[i].euf);
    end
    // set beats clear in the wrap cycle
    drive(0, 1, 8'hFF, 1, 1, 0, 0, 0);
    check("coll_load", 8'hFF, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 1, 1, 0);
    check("coll_wrap", 8'h00, 1, 0, 1, 0);
    drive(0, 0, 8'h00, 1, 1, 0, 1, 0);
    check("coll_clear", 8'h00, 0, 0, 0, 0);
    // udf set then cleared by reset; tick during reset is discarded
    drive(0, 1, 8'h00, 1, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 1, 0, 0);
    check("udf_from0", 8'hFF, 0, 1, 0, 1);
    drive(1, 0, 8'h00, 1, 0, 0, 0, 0);
    check("mid_reset", 8'h00, 0, 0, 0, 0);
    drive(1, 0, 8'h00, 1, 1, 1, 0, 0);
    check("reset_tick", 8'h00, 0, 0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 1, 0, 0);
    check("post_reset", 8'h00, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
